// File: rtl/adc_capture_engine.sv
`default_nettype none
// ============================================================================
// Module : adc_capture_engine
// Multi-channel ADC circular-buffer capture with level/slope trigger and
// programmable pre-trigger depth; indexed readout of the frozen waveform.
// Rev    : 1.0
// ============================================================================
module adc_capture_engine #(
  parameter int NUM_CH = 2,
  parameter int ADC_W  = 14,
  parameter int DEPTH  = 1000,
  parameter int PRE_W  = 10,
  parameter int OUT_W  = 16,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    sys_clk,
  input  logic                    reset_n,
  input  logic [NUM_CH*ADC_W-1:0] adc_data,
  input  logic                    arm,
  input  logic                    abort,
  input  logic [CH_W-1:0]         trig_src,
  input  logic                    trig_slope,
  input  logic [ADC_W-1:0]        trig_level,
  input  logic [PRE_W-1:0]        pretrig,
  input  logic                    force_trig,
  input  logic [CH_W-1:0]         rd_ch,
  input  logic [15:0]             rd_addr,
  output logic [OUT_W-1:0]        rd_data,
  output logic                    busy,
  output logic                    wave_ready,
  output logic [15:0]             wave_count
);

  localparam int              PW          = $clog2(DEPTH);
  localparam logic [PW-1:0]   C_LAST_PTR  = PW'(DEPTH - 1);
  localparam logic [31:0]     C_PRE_MAX   = 32'(DEPTH - 1);
  localparam logic [16:0]     C_DEPTH_X   = 17'(DEPTH);
  localparam logic [CH_W:0]   C_NUM_CH_X  = (CH_W + 1)'(NUM_CH);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PREFILL = 3'd1,
    ST_ARMED   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t             r_state;
  logic [ADC_W-1:0]   r_cur  [NUM_CH];
  logic [ADC_W-1:0]   r_prev [NUM_CH];
  logic [ADC_W-1:0]   r_mem  [NUM_CH][DEPTH];
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_cnt;
  logic [PW-1:0]      r_pre;
  logic [PW-1:0]      r_start;
  logic [CH_W-1:0]    r_src;
  logic               r_slope;
  logic [ADC_W-1:0]   r_level;

  logic               w_wr_en;
  logic [31:0]        w_pretrig_ext;
  logic [PW-1:0]      w_pre_arm;
  logic [PW-1:0]      w_post;
  logic [ADC_W-1:0]   w_tcur;
  logic [ADC_W-1:0]   w_tprev;
  logic               w_trig;
  logic [PW-1:0]      w_start;
  logic               w_addr_ok;
  logic               w_ch_ok;
  logic               w_rd_valid;
  logic [CH_W-1:0]    w_rd_ch;
  logic [PW-1:0]      w_rd_idx;

  // (a + b) mod DEPTH for operands whose sum stays below 2*DEPTH
  function automatic logic [PW-1:0] wrap_add(input logic [16:0] a, input logic [16:0] b);
    logic [16:0] s;
    s = a + b;
    if (s >= C_DEPTH_X) s = s - C_DEPTH_X;
    return PW'(s);
  endfunction

  assign w_wr_en       = (r_state == ST_PREFILL) || (r_state == ST_ARMED) || (r_state == ST_CAPTURE);
  assign w_pretrig_ext = 32'(pretrig);
  assign w_pre_arm     = (w_pretrig_ext > C_PRE_MAX) ? C_LAST_PTR : PW'(w_pretrig_ext);
  assign w_post        = C_LAST_PTR - r_pre;
  assign w_tcur        = r_cur[r_src];
  assign w_tprev       = r_prev[r_src];
  assign w_trig        = force_trig ||
                         (r_slope ? ((w_tprev > r_level) && (w_tcur <= r_level))
                                  : ((w_tprev < r_level) && (w_tcur >= r_level)));
  assign w_start       = wrap_add(17'(r_wr_ptr), C_DEPTH_X - 17'(r_pre));

  assign w_addr_ok     = ({1'b0, rd_addr} < C_DEPTH_X);
  assign w_ch_ok       = ({1'b0, rd_ch} < C_NUM_CH_X);
  assign w_rd_valid    = (r_state == ST_DONE) && w_addr_ok && w_ch_ok;
  assign w_rd_ch       = w_ch_ok ? rd_ch : '0;
  assign w_rd_idx      = w_addr_ok ? wrap_add(17'(r_start), {1'b0, rd_addr}) : '0;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_cur[c]  <= '0;
        r_prev[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_cur[c]  <= adc_data[c*ADC_W +: ADC_W];
        r_prev[c] <= r_cur[c];
      end
    end
  end

  // Buffer RAM carries no reset; reads outside DONE are forced to zero.
  always_ff @(posedge sys_clk) begin
    if (w_wr_en) begin
      for (int c = 0; c < NUM_CH; c++) r_mem[c][r_wr_ptr] <= r_cur[c];
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) rd_data <= '0;
    else          rd_data <= w_rd_valid ? OUT_W'(r_mem[w_rd_ch][w_rd_idx]) : '0;
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_wr_ptr   <= '0;
      r_cnt      <= '0;
      r_pre      <= '0;
      r_start    <= '0;
      r_src      <= '0;
      r_slope    <= 1'b0;
      r_level    <= '0;
      busy       <= 1'b0;
      wave_ready <= 1'b0;
      wave_count <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= (r_wr_ptr == C_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;

      if (abort) begin
        r_state    <= ST_IDLE;
        busy       <= 1'b0;
        wave_ready <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE, ST_DONE: begin
            if (arm) begin
              r_pre      <= w_pre_arm;
              r_src      <= trig_src;
              r_slope    <= trig_slope;
              r_level    <= trig_level;
              r_cnt      <= '0;
              r_state    <= (w_pre_arm == '0) ? ST_ARMED : ST_PREFILL;
              busy       <= 1'b1;
              wave_ready <= 1'b0;
            end
          end
          ST_PREFILL: begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == r_pre - 1'b1) r_state <= ST_ARMED;
          end
          ST_ARMED: begin
            // The sample written this cycle becomes the trigger sample.
            if (w_trig) begin
              r_start <= w_start;
              r_cnt   <= '0;
              if (w_post == '0) begin
                r_state    <= ST_DONE;
                busy       <= 1'b0;
                wave_ready <= 1'b1;
                wave_count <= wave_count + 1'b1;
              end else begin
                r_state <= ST_CAPTURE;
              end
            end
          end
          ST_CAPTURE: begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == w_post - 1'b1) begin
              r_state    <= ST_DONE;
              busy       <= 1'b0;
              wave_ready <= 1'b1;
              wave_count <= wave_count + 1'b1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
